// File: rtl/fft_frame_sequencer.sv
// Frame sequencer between the decimated audio stream and the FFT chain.
// Collects one frame, drains the FFT, then publishes the peak bin.
module fft_frame_sequencer #(
  parameter int FRAME_LEN = 1024,
  parameter int IDX_W     = 10,
  parameter int TIMEOUT   = 65535
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             enable_in,
  input  logic [7:0]       sample_in,
  input  logic             sample_valid_in,
  input  logic             fft_ready_in,
  output logic [7:0]       win_sample_out,
  output logic [IDX_W-1:0] win_index_out,
  output logic             win_valid_out,
  output logic             win_first_out,
  input  logic             fft_out_valid_in,
  input  logic             fft_out_last_in,
  output logic             fft_out_ready_out,
  input  logic [11:0]      peak_in,
  input  logic             peak_valid_in,
  output logic [11:0]      note_bin_out,
  output logic             note_valid_out,
  output logic             busy_out,
  output logic [15:0]      dropped_count_out,
  output logic             timeout_err_out
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_PEAK  = 2'd3;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [IDX_W-1:0] idx;
  logic [WD_W-1:0]  wd;
  logic             accept;
  logic             drop;
  logic             abort;
  logic             publish;

  // Next state and per-cycle events; a watchdog abort overrides everything.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    drop    = 1'b0;
    abort   = 1'b0;
    publish = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (sample_valid_in && enable_in) begin
          if (fft_ready_in) begin
            accept  = 1'b1;
            state_n = S_FILL;
          end else begin
            drop = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (sample_valid_in) begin
          if (fft_ready_in) begin
            accept = 1'b1;
            if (idx == IDX_LAST) state_n = S_DRAIN;
          end else begin
            drop = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        drop = sample_valid_in;
        if (fft_out_valid_in && fft_out_last_in) state_n = S_PEAK;
        else if (wd == WD_LAST) abort = 1'b1;
      end
      S_PEAK: begin
        drop = sample_valid_in;
        if (peak_valid_in) begin
          publish = 1'b1;
          state_n = S_IDLE;
        end else if (wd == WD_LAST) begin
          abort = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end

  // State, frame index and watchdog counter.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= S_IDLE;
      idx   <= '0;
      wd    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        if (state == S_IDLE) idx <= IDX_W'(1);
        else                 idx <= idx + 1'b1;
      end
      if (state_n != state) wd <= '0;
      else if (state == S_DRAIN || state == S_PEAK) wd <= wd + 1'b1;
    end
  end

  // Registered window-stage outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      win_sample_out <= '0;
      win_index_out  <= '0;
      win_valid_out  <= 1'b0;
      win_first_out  <= 1'b0;
    end else begin
      win_valid_out <= accept;
      win_first_out <= accept && (state == S_IDLE);
      if (accept) begin
        win_sample_out <= sample_in;
        win_index_out  <= (state == S_IDLE) ? '0 : idx;
      end
    end
  end

  // Published note, drop counter and sticky watchdog flag.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      note_bin_out      <= '0;
      note_valid_out    <= 1'b0;
      dropped_count_out <= '0;
      timeout_err_out   <= 1'b0;
    end else begin
      note_valid_out <= publish;
      if (publish) note_bin_out <= peak_in;
      if (drop && dropped_count_out != 16'hFFFF)
        dropped_count_out <= dropped_count_out + 16'd1;
      if (abort) timeout_err_out <= 1'b1;
    end
  end

  assign busy_out          = (state != S_IDLE);
  assign fft_out_ready_out = (state == S_DRAIN);

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: reset-start vector table, directed
// sequences and random traffic against a frame-level reference model.
module tb_fft_frame_sequencer;

  localparam int FL = 16;
  localparam int IW = 4;
  localparam int TO = 24;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          enable_in = 1'b0;
  logic [7:0]    sample_in = '0;
  logic          sample_valid_in = 1'b0;
  logic          fft_ready_in = 1'b0;
  logic [7:0]    win_sample_out;
  logic [IW-1:0] win_index_out;
  logic          win_valid_out;
  logic          win_first_out;
  logic          fft_out_valid_in = 1'b0;
  logic          fft_out_last_in = 1'b0;
  logic          fft_out_ready_out;
  logic [11:0]   peak_in = '0;
  logic          peak_valid_in = 1'b0;
  logic [11:0]   note_bin_out;
  logic          note_valid_out;
  logic          busy_out;
  logic [15:0]   dropped_count_out;
  logic          timeout_err_out;

  fft_frame_sequencer #(
    .FRAME_LEN(FL),
    .IDX_W(IW),
    .TIMEOUT(TO)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .enable_in(enable_in),
    .sample_in(sample_in),
    .sample_valid_in(sample_valid_in),
    .fft_ready_in(fft_ready_in),
    .win_sample_out(win_sample_out),
    .win_index_out(win_index_out),
    .win_valid_out(win_valid_out),
    .win_first_out(win_first_out),
    .fft_out_valid_in(fft_out_valid_in),
    .fft_out_last_in(fft_out_last_in),
    .fft_out_ready_out(fft_out_ready_out),
    .peak_in(peak_in),
    .peak_valid_in(peak_valid_in),
    .note_bin_out(note_bin_out),
    .note_valid_out(note_valid_out),
    .busy_out(busy_out),
    .dropped_count_out(dropped_count_out),
    .timeout_err_out(timeout_err_out)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a frame is "collecting" samples, then "awaiting"
  // the FFT's last beat, then "awaiting" the peak; waits are timed.
  bit          collecting, await_fft, await_peak;
  int          taken, waited;
  bit          e_wv, e_wf, e_nv, e_te;
  logic [3:0]  e_wi;
  logic [7:0]  e_ws;
  logic [11:0] e_nb;
  logic [15:0] e_dc;

  task automatic model_reset();
    collecting = 0; await_fft = 0; await_peak = 0;
    taken = 0; waited = 0;
    e_wv = 0; e_wf = 0; e_nv = 0; e_te = 0;
    e_wi = '0; e_ws = '0; e_nb = '0; e_dc = '0;
  endtask

  task automatic model_step(input bit sv, en, rdy, input logic [7:0] s,
                            input bit ov, ol, pv, input logic [11:0] pk);
    bit lost;
    lost = 0;
    e_wv = 0; e_wf = 0; e_nv = 0;
    if (await_fft) begin
      lost = sv;
      waited++;
      if (ov && ol) begin
        await_fft = 0; await_peak = 1; waited = 0;
      end else if (waited == TO) begin
        await_fft = 0; e_te = 1;
      end
    end else if (await_peak) begin
      lost = sv;
      waited++;
      if (pv) begin
        await_peak = 0; e_nv = 1; e_nb = pk;
      end else if (waited == TO) begin
        await_peak = 0; e_te = 1;
      end
    end else if (sv && (collecting || en)) begin
      if (rdy) begin
        e_wv = 1; e_ws = s; e_wi = 4'(taken); e_wf = (taken == 0);
        taken++;
        collecting = 1;
        if (taken == FL) begin
          collecting = 0; taken = 0; await_fft = 1; waited = 0;
        end
      end else begin
        lost = 1;
      end
    end
    if (lost && e_dc != 16'hFFFF) e_dc = e_dc + 16'd1;
  endtask

  function automatic logic [63:0] act_bundle();
    return {18'd0, win_valid_out, win_index_out, win_sample_out,
            win_first_out, note_valid_out, note_bin_out, busy_out,
            fft_out_ready_out, dropped_count_out, timeout_err_out};
  endfunction

  function automatic logic [63:0] exp_bundle();
    return {18'd0, e_wv, e_wi, e_ws, e_wf, e_nv, e_nb,
            collecting || await_fft || await_peak, await_fft, e_dc, e_te};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input bit sv, en, rdy, input logic [7:0] s,
                      input bit ov, ol, pv, input logic [11:0] pk);
    sample_valid_in = sv; enable_in = en; fft_ready_in = rdy;
    sample_in = s; fft_out_valid_in = ov; fft_out_last_in = ol;
    peak_valid_in = pv; peak_in = pk;
    @(posedge clk_in);
    model_step(sv, en, rdy, s, ov, ol, pv, pk);
    #1;
    check("cycle", act_bundle(), exp_bundle());
  endtask

  task automatic idle_tick();
    tick(0, 0, 0, 8'h00, 0, 0, 0, 12'h000);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    #2;
    check("reset_outputs", act_bundle(), 64'd0);
    model_reset();
    sample_valid_in = 0; enable_in = 0; fft_ready_in = 0;
    fft_out_valid_in = 0; fft_out_last_in = 0; peak_valid_in = 0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  task automatic fill_frame();
    for (int i = 0; i < FL; i++) tick(1, 1, 1, 8'(i), 0, 0, 0, 12'h000);
  endtask

  typedef struct {
    bit         en, rdy, sv, pv;
    logic [7:0] s;
    bit         e_wv, e_wf, e_busy, e_nv;
    logic [7:0] e_ws;
    logic [15:0] e_dc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1, 1, 1, 0, 8'h5A, 1, 1, 1, 0, 8'h5A, 16'd0};
    tbl[1] = '{1, 0, 1, 0, 8'h11, 0, 0, 0, 0, 8'h00, 16'd1};
    tbl[2] = '{0, 1, 1, 0, 8'h22, 0, 0, 0, 0, 8'h00, 16'd0};
    tbl[3] = '{1, 1, 0, 0, 8'h33, 0, 0, 0, 0, 8'h00, 16'd0};
    tbl[4] = '{0, 0, 1, 0, 8'h44, 0, 0, 0, 0, 8'h00, 16'd0};
    tbl[5] = '{1, 1, 1, 0, 8'h80, 1, 1, 1, 0, 8'h80, 16'd0};
    tbl[6] = '{0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00, 16'd0};

    for (int i = 0; i < 7; i++) begin
      do_reset();
      tick(tbl[i].sv, tbl[i].en, tbl[i].rdy, tbl[i].s, 0, 0,
           tbl[i].pv, 12'h123);
      check("table", {win_valid_out, win_first_out, busy_out,
                      note_valid_out, win_sample_out, dropped_count_out},
            {tbl[i].e_wv, tbl[i].e_wf, tbl[i].e_busy, tbl[i].e_nv,
             tbl[i].e_ws, tbl[i].e_dc});
    end

    // Nominal frame
    do_reset();
    for (int i = 0; i < FL; i++) begin
      tick(1, 1, 1, 8'(i), 0, 0, 0, 12'h000);
      check("nom_idx", {win_valid_out, win_index_out, win_first_out},
            {1'b1, 4'(i), i == 0});
    end
    check("nom_ready_first", {fft_out_ready_out, busy_out}, 2'b11);
    for (int c = 0; c < 19; c++) idle_tick();
    check("nom_ready_held", fft_out_ready_out, 1'b1);
    tick(0, 1, 1, 8'h00, 1, 1, 0, 12'h000);
    check("nom_ready_low", {fft_out_ready_out, busy_out}, 2'b01);
    tick(0, 1, 1, 8'h00, 0, 0, 1, 12'h02A);
    check("nom_note", {note_valid_out, note_bin_out}, {1'b1, 12'h02A});
    idle_tick();
    check("nom_note_hold", {note_valid_out, note_bin_out, busy_out},
          {1'b0, 12'h02A, 1'b0});
    check("nom_dropped", dropped_count_out, 16'd0);

    // Backpressure mid-FILL
    do_reset();
    begin
      int k;
      k = 0;
      for (int i = 0; i < FL + 3; i++) begin
        bit bp;
        bp = (i >= 5 && i < 8);
        tick(1, 1, !bp, 8'(i), 0, 0, 0, 12'h000);
        if (bp) begin
          check("bp_hold", win_valid_out, 1'b0);
        end else begin
          check("bp_idx", {win_valid_out, win_index_out}, {1'b1, 4'(k)});
          k++;
        end
      end
    end
    check("bp_dropped", dropped_count_out, 16'd3);
    check("bp_complete", {busy_out, fft_out_ready_out}, 2'b11);
    tick(0, 0, 0, 8'h00, 1, 1, 0, 12'h000);
    tick(0, 0, 0, 8'h00, 0, 0, 1, 12'h155);
    check("bp_note", {note_valid_out, note_bin_out}, {1'b1, 12'h155});

    // Drops while busy, ignore while disabled
    do_reset();
    fill_frame();
    for (int i = 0; i < 5; i++) tick(1, 1, 1, 8'h77, 0, 0, 0, 12'h000);
    tick(0, 1, 1, 8'h00, 1, 1, 0, 12'h000);
    for (int i = 0; i < 2; i++) tick(1, 1, 1, 8'h66, 0, 0, 0, 12'h000);
    tick(0, 1, 1, 8'h00, 0, 0, 1, 12'h0F0);
    for (int i = 0; i < 4; i++) tick(1, 0, 1, 8'h55, 0, 0, 0, 12'h000);
    check("busy_dropped", dropped_count_out, 16'd7);

    // Watchdog on a stalled FFT
    do_reset();
    fill_frame();
    begin
      int notes;
      notes = 0;
      for (int c = 0; c < TO - 1; c++) begin
        idle_tick();
        notes += int'(note_valid_out);
      end
      check("wd_still_busy", {busy_out, timeout_err_out}, 2'b10);
      idle_tick();
      notes += int'(note_valid_out);
      check("wd_abort", {busy_out, fft_out_ready_out, timeout_err_out},
            3'b001);
      check("wd_no_note", notes, 0);
    end
    tick(1, 1, 1, 8'h3C, 0, 0, 0, 12'h000);
    check("wd_restart", {win_valid_out, win_first_out, win_index_out,
                         win_sample_out}, {2'b11, 4'd0, 8'h3C});

    // Asynchronous reset mid-FILL
    do_reset();
    for (int i = 0; i < 9; i++) tick(1, 1, 1, 8'(i), 0, 0, 0, 12'h000);
    do_reset();
    tick(1, 1, 1, 8'hA5, 0, 0, 0, 12'h000);
    check("rst_restart", {win_valid_out, win_first_out, win_index_out},
          {2'b11, 4'd0});

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 8, 8'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) == 0, 12'($urandom));
    end

    // Drop counter saturation
    do_reset();
    for (int c = 0; c < 66000; c++) tick(1, 1, 0, 8'h01, 0, 0, 0, 12'h000);
    check("sat_count", dropped_count_out, 16'hFFFF);
    tick(1, 1, 0, 8'h01, 0, 0, 0, 12'h000);
    check("sat_hold", dropped_count_out, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
